// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus player: FSM states and the bit
// positions of the two flag bits stored with every vector word.
package stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Stored word layout is {last, obs, payload}; the flags sit directly above
  // the payload, so their absolute index is DATA_W + offset.
  localparam int OBS_BIT  = 0;
  localparam int LAST_BIT = 1;

endpackage

// File: rtl/stim_player_if.sv
// Output vector stream of the stimulus player: valid/ready handshake plus
// the presented payload, its observe flag and its word index.
interface stim_player_if #(
  parameter int DATA_W = 128,
  parameter int AW     = 3
) ();

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] vec_out;
  logic              obs_out;
  logic [AW-1:0]     pc;

  modport master (output out_valid, output vec_out, output obs_out, output pc, input out_ready);
  modport slave  (input out_valid, input vec_out, input obs_out, input pc, output out_ready);

endinterface

// File: rtl/stim_ram.sv
// Vector word storage: synchronous write, combinational read. Contents are
// deliberately not reset so a loaded pattern survives a reset.
module stim_ram #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 6,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W+1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W+1:0] rdata
);

  logic [DATA_W+1:0] mem_q [DEPTH];

  // Write port; addresses beyond DEPTH (non power-of-two depth) are dropped.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/stim_player.sv
// Stimulus player: plays stored vector words out over a valid/ready stream,
// one pass ending at a word flagged last (or the final slot), repeated
// loop_cnt times (0 = until stopped).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | not playing; memory writable; waits for start
//   ST_RUN  | presenting word pc with out_valid=1
//   ST_FIN  | one cycle after the final transfer; done pulses here
module stim_player
  import stim_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 6,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W+1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        loop_cnt,
  stim_player_if.master     sp,
  output logic              busy,
  output logic              done,
  output logic              wr_drop
);

  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

  state_e            state_q;
  logic [AW-1:0]     pc_q;
  logic [AW-1:0]     rd_addr_d;
  logic              valid_q;
  logic [DATA_W-1:0] vec_q;
  logic              obs_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_drop_q;
  logic [7:0]        pass_q;
  logic [7:0]        loop_q;
  logic [DATA_W+1:0] rd_word;
  logic              xfer;
  logic              pass_final;
  logic              more_passes;
  logic              ram_we;

  assign xfer        = valid_q & sp.out_ready;
  assign pass_final  = last_q | (pc_q == PC_LAST);
  // 9-bit compare so loop_cnt=255 plays exactly 255 passes.
  assign more_passes = (loop_q == 8'd0) | (({1'b0, pass_q} + 9'd1) < {1'b0, loop_q});
  assign ram_we      = wr_en & (state_q == ST_IDLE);

  stim_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr_d),
    .rdata (rd_word)
  );

  // Address of the word to present next cycle: word 0 on start or wrap,
  // pc+1 after a non-final transfer, otherwise the current word.
  always_comb begin
    rd_addr_d = '0;
    if (state_q == ST_RUN) begin
      rd_addr_d = pc_q;
      if (xfer) begin
        rd_addr_d = pass_final ? '0 : pc_q + 1'b1;
      end
    end
  end

  // Sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      valid_q   <= 1'b0;
      vec_q     <= '0;
      obs_q     <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      pass_q    <= '0;
      loop_q    <= '0;
    end else begin
      done_q    <= 1'b0;
      wr_drop_q <= wr_en & (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_q <= ST_RUN;
            valid_q <= 1'b1;
            pc_q    <= rd_addr_d;
            vec_q   <= rd_word[DATA_W-1:0];
            obs_q   <= rd_word[DATA_W+OBS_BIT];
            last_q  <= rd_word[DATA_W+LAST_BIT];
            busy_q  <= 1'b1;
            pass_q  <= '0;
            loop_q  <= loop_cnt;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            pc_q    <= '0;
            vec_q   <= '0;
            obs_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (xfer) begin
            if (pass_final) begin
              pass_q <= pass_q + 8'd1;
            end
            if (pass_final && !more_passes) begin
              state_q <= ST_FIN;
              valid_q <= 1'b0;
              pc_q    <= '0;
              vec_q   <= '0;
              obs_q   <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pc_q   <= rd_addr_d;
              vec_q  <= rd_word[DATA_W-1:0];
              obs_q  <= rd_word[DATA_W+OBS_BIT];
              last_q <= rd_word[DATA_W+LAST_BIT];
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sp.out_valid = valid_q;
  assign sp.vec_out   = vec_q;
  assign sp.obs_out   = obs_q;
  assign sp.pc        = pc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wr_drop      = wr_drop_q;

endmodule

// File: tb/tb_stim_player.sv
// Bench for stim_player: the expected output stream is derived from a plain
// array copy of the loaded words and the pass/last rules.
module tb_stim_player;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 6;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DATA_W+1:0] wr_data = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [7:0]        loop_cnt = 8'd1;
  logic              busy;
  logic              done;
  logic              wr_drop;

  stim_player_if #(.DATA_W(DATA_W), .AW(AW)) sp_if ();

  stim_player #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .stop     (stop),
    .loop_cnt (loop_cnt),
    .sp       (sp_if.master),
    .busy     (busy),
    .done     (done),
    .wr_drop  (wr_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference copy of memory contents
  logic [DATA_W-1:0] m_pay  [DEPTH];
  logic              m_obs  [DEPTH];
  logic              m_last [DEPTH];

  typedef struct {
    logic [AW-1:0]     pc;
    logic [DATA_W-1:0] pay;
    logic              obs;
  } exp_t;
  exp_t exp_q[$];

  task automatic load_word(input int a, input logic [DATA_W-1:0] p, input logic o, input logic l);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = {l, o, p};
    @(posedge clk); #1;
    wr_en     = 1'b0;
    m_pay[a]  = p;
    m_obs[a]  = o;
    m_last[a] = l;
  endtask

  // Payload i+1, obs on word 2, last on word last_idx (-1: none)
  task automatic load_basic(input int last_idx);
    for (int i = 0; i < DEPTH; i++)
      load_word(i, DATA_W'(i + 1), (i == 2), (i == last_idx));
  endtask

  task automatic load_random();
    for (int i = 0; i < DEPTH; i++)
      load_word(i, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                (($urandom_range(0, 3)) == 0));
  endtask

  // Expected stream: each pass walks words from 0 until a last flag or the end
  task automatic build_exp(input int passes);
    exp_t e;
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        e.pc  = AW'(i);
        e.pay = m_pay[i];
        e.obs = m_obs[i];
        exp_q.push_back(e);
        if (m_last[i]) break;
      end
    end
  endtask

  // Start a run and follow it word by word to the done pulse
  task automatic play(input int passes, input bit rnd, input int stall_idx, input int stall_len,
                      input string tag);
    int idx, stall, cyc, budget;
    bit rdy;
    build_exp(passes);
    budget = exp_q.size() * 20 + 50;
    idx = 0; stall = 0; cyc = 0;
    loop_cnt = 8'(passes);
    start = 1'b1;
    sp_if.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < exp_q.size() && cyc < budget) begin
      n_checks++;
      if (sp_if.out_valid !== 1'b1 || sp_if.pc !== exp_q[idx].pc || sp_if.vec_out !== exp_q[idx].pay ||
          sp_if.obs_out !== exp_q[idx].obs || busy !== 1'b1) begin
        n_fails++;
        $display("FAIL %s word %0d: valid=%b pc=%0d vec=%h obs=%b busy=%b, required valid=1 pc=%0d vec=%h obs=%b busy=1",
                 tag, idx, sp_if.out_valid, sp_if.pc, sp_if.vec_out, sp_if.obs_out, busy,
                 exp_q[idx].pc, exp_q[idx].pay, exp_q[idx].obs);
      end
      n_checks++;
      if (done !== 1'b0) begin
        n_fails++;
        $display("FAIL %s early_done word %0d: done=%b, required 0", tag, idx, done);
      end
      if (idx == stall_idx && stall < stall_len) begin
        rdy = 1'b0;
        stall++;
      end else if (rnd) begin
        rdy = 1'($urandom_range(0, 1));
      end else begin
        rdy = 1'b1;
      end
      if (rnd) begin
        start    = ($urandom_range(0, 3) == 0);
        loop_cnt = 8'($urandom);
      end
      sp_if.out_ready = rdy;
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    start = 1'b0;
    sp_if.out_ready = 1'b0;
    n_checks++;
    if (idx < exp_q.size()) begin
      n_fails++;
      $display("FAIL %s timeout: %0d of %0d words after %0d cycles", tag, idx, exp_q.size(), cyc);
    end
    n_checks++;
    if (done !== 1'b1 || sp_if.out_valid !== 1'b0 || sp_if.vec_out !== '0 || sp_if.obs_out !== 1'b0 ||
        busy !== 1'b1) begin
      n_fails++;
      $display("FAIL %s fin: done=%b valid=%b vec=%h obs=%b busy=%b, required done=1 valid=0 vec=0 obs=0 busy=1",
               tag, done, sp_if.out_valid, sp_if.vec_out, sp_if.obs_out, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sp_if.out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL %s after_fin: done=%b busy=%b valid=%b, required all 0", tag, done, busy, sp_if.out_valid);
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (sp_if.out_valid !== 1'b0 || sp_if.vec_out !== '0 || sp_if.obs_out !== 1'b0 || sp_if.pc !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || wr_drop !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_state: valid=%b vec=%h obs=%b pc=%0d busy=%b done=%b wr_drop=%b, required all 0",
               sp_if.out_valid, sp_if.vec_out, sp_if.obs_out, sp_if.pc, busy, done, wr_drop);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (sp_if.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_release: valid=%b busy=%b done=%b, required all 0", sp_if.out_valid, busy, done);
    end
  endtask

  task automatic test_basic();
    load_basic(-1);
    play(1, 1'b0, -1, 0, "basic");
  endtask

  task automatic test_last_loop();
    load_basic(3);
    play(2, 1'b0, -1, 0, "last_loop2");
  endtask

  task automatic test_stall();
    load_basic(-1);
    play(1, 1'b0, 1, 3, "stall");
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      load_random();
      play(int'($urandom_range(1, 3)), 1'b1, -1, 0, "random");
    end
  endtask

  task automatic test_loop255();
    load_word(0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
    play(255, 1'b0, -1, 0, "loop255");
  endtask

  task automatic test_forever();
    int cyc;
    load_basic(1);
    build_exp(5);
    loop_cnt = 8'd0;
    start = 1'b1;
    sp_if.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (sp_if.out_valid !== 1'b1 || sp_if.pc !== exp_q[i].pc || sp_if.vec_out !== exp_q[i].pay ||
          done !== 1'b0) begin
        n_fails++;
        $display("FAIL forever word %0d: valid=%b pc=%0d vec=%h done=%b, required valid=1 pc=%0d vec=%h done=0",
                 i, sp_if.out_valid, sp_if.pc, sp_if.vec_out, done, exp_q[i].pc, exp_q[i].pay);
      end
      @(posedge clk); #1;
    end
    // Stop on pc=3 territory is covered elsewhere; here just end the endless run
    cyc = 0;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    sp_if.out_ready = 1'b0;
    n_checks++;
    if (sp_if.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fails++;
      $display("FAIL forever_stop: valid=%b busy=%b done=%b, required all 0", sp_if.out_valid, busy, done);
    end
  endtask

  task automatic test_stop();
    int cyc;
    load_basic(-1);
    loop_cnt = 8'd1;
    start = 1'b1;
    sp_if.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (sp_if.pc !== AW'(3) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (sp_if.pc !== AW'(3) || sp_if.out_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL stop_reach: pc=%0d valid=%b, required pc=3 valid=1", sp_if.pc, sp_if.out_valid);
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    n_checks++;
    if (sp_if.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sp_if.vec_out !== '0 ||
        sp_if.obs_out !== 1'b0) begin
      n_fails++;
      $display("FAIL stop: valid=%b busy=%b done=%b vec=%h obs=%b, required all 0",
               sp_if.out_valid, busy, done, sp_if.vec_out, sp_if.obs_out);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || sp_if.out_valid !== 1'b0) begin
        n_fails++;
        $display("FAIL stop_quiet %0d: done=%b valid=%b, required 0 0", i, done, sp_if.out_valid);
      end
    end
    sp_if.out_ready = 1'b0;
  endtask

  task automatic test_wr_drop();
    load_basic(-1);
    n_checks++;
    if (wr_drop !== 1'b0) begin
      n_fails++;
      $display("FAIL wr_idle: wr_drop=%b, required 0", wr_drop);
    end
    loop_cnt = 8'd1;
    start = 1'b1;
    sp_if.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b1;
    wr_addr = AW'(1);
    wr_data = {1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom}};
    @(posedge clk); #1;
    wr_en = 1'b0;
    n_checks++;
    if (wr_drop !== 1'b1 || sp_if.out_valid !== 1'b1 || sp_if.pc !== '0) begin
      n_fails++;
      $display("FAIL wr_drop_pulse: wr_drop=%b valid=%b pc=%0d, required 1 1 0", wr_drop, sp_if.out_valid, sp_if.pc);
    end
    @(posedge clk); #1;
    n_checks++;
    if (wr_drop !== 1'b0) begin
      n_fails++;
      $display("FAIL wr_drop_clear: wr_drop=%b, required 0", wr_drop);
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    play(1, 1'b0, -1, 0, "wr_drop_replay");
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (sp_if.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fails++;
        $display("FAIL start_stop %0d: valid=%b busy=%b done=%b, required all 0", i, sp_if.out_valid, busy, done);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    load_basic(-1);
    loop_cnt = 8'd1;
    start = 1'b1;
    sp_if.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (sp_if.pc !== AW'(4) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (sp_if.pc !== AW'(4) || sp_if.out_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL rst_reach: pc=%0d valid=%b, required pc=4 valid=1", sp_if.pc, sp_if.out_valid);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (sp_if.out_valid !== 1'b0 || sp_if.vec_out !== '0 || sp_if.obs_out !== 1'b0 || sp_if.pc !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || wr_drop !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_async: valid=%b vec=%h obs=%b pc=%0d busy=%b done=%b wr_drop=%b, required all 0",
               sp_if.out_valid, sp_if.vec_out, sp_if.obs_out, sp_if.pc, busy, done, wr_drop);
    end
    sp_if.out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (sp_if.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_idle: valid=%b busy=%b done=%b, required all 0", sp_if.out_valid, busy, done);
    end
    play(1, 1'b0, -1, 0, "rst_replay");
  endtask

  initial begin
    sp_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_last_loop();
    test_stall();
    test_random();
    test_loop255();
    test_forever();
    test_stop();
    test_wr_drop();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
